// File: rtl/bist_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : bist_pkg
// Purpose : Shared BIST definitions: analyzer FSM states, default MISR
//           polynomial and the matching pattern-generator LFSR constants.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package bist_pkg;

   // Response-analyzer control states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPACT = 2'd1,
      COMPARE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Default MISR feedback taps (x^8 + x^4 + x^3 + x^2 + 1)
   localparam logic [7:0] DEFAULT_POLY = 8'h1D;

   // Pattern-generator LFSR built from the same polynomial, so that the
   // stimulus and the compaction share one characteristic polynomial
   localparam logic [7:0] PG_POLY = DEFAULT_POLY;
   localparam logic [7:0] PG_SEED = 8'h01;

endpackage : bist_pkg
`default_nettype wire

// File: rtl/misr.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : misr
// Purpose : Multiple-input signature register. Shifts left with polynomial
//           feedback from the MSB and folds in one data word per enable.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module misr
   import bist_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] sig
);

   logic [WIDTH-1:0] r_sig;
   logic [WIDTH-1:0] w_next;

   // Next signature: shift, feed back taps when the MSB falls out, fold in data
   always_comb begin
      w_next = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ data;
   end

   // Signature register; clear has priority so a new run always starts at zero
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sig <= '0;
      end else if (clear) begin
         r_sig <= '0;
      end else if (enable) begin
         r_sig <= w_next;
      end
   end

   assign sig = r_sig;

endmodule : misr
`default_nettype wire

// File: rtl/bist_response_analyzer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : bist_response_analyzer
// Purpose : Compacts NUM_PATTERNS circuit-under-test responses into a MISR
//           signature and compares it against a golden value.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module bist_response_analyzer
   import bist_pkg::*;
#(
   parameter int               WIDTH        = 8,
   parameter int               NUM_PATTERNS = 256,
   parameter logic [WIDTH-1:0] POLY         = WIDTH'(DEFAULT_POLY)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             resp_valid,
   input  logic [WIDTH-1:0] resp_data,
   input  logic [WIDTH-1:0] golden_sig,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature,
   output logic [15:0]      count
);

   // Count value held just before the final response is accepted
   localparam logic [15:0] c_last_idx = 16'(NUM_PATTERNS - 1);

   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [15:0]      r_count;
   logic             w_clear;
   logic             w_accept;
   logic [WIDTH-1:0] w_sig;

   // A run may only be launched from IDLE or DONE; responses only count in COMPACT
   always_comb begin
      w_clear  = start && ((r_state == IDLE) || (r_state == DONE));
      w_accept = resp_valid && (r_state == COMPACT);
   end

   misr #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_misr (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (w_clear),
      .enable (w_accept),
      .data   (resp_data),
      .sig    (w_sig)
   );

   // Control FSM with counter, comparator and registered status outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_count <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state <= COMPACT;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
                  r_count <= '0;
               end
            end
            COMPACT: begin
               if (resp_valid) begin
                  r_count <= r_count + 16'd1;
                  // Leave as soon as the last response lands; count stops at NUM_PATTERNS
                  if (r_count == c_last_idx) begin
                     r_state <= COMPARE;
                  end
               end
            end
            COMPARE: begin
               r_pass  <= (w_sig == golden_sig);
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= DONE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_pass  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign signature = w_sig;
   assign count     = r_count;

endmodule : bist_response_analyzer
`default_nettype wire

// File: doc/bist_response_analyzer.md
BIST_RESPONSE_ANALYZER -- requirements
Module: bist_response_analyzer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the response bus and of the signature (legal range 2..32).
REQ-002 SHALL have parameter NUM_PATTERNS, default 256: number of accepted responses compacted per run (legal range 1..65535).
REQ-003 SHALL have parameter POLY, default 8'h1D: MISR feedback polynomial taps, WIDTH bits wide.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: begin a run; sampled only in IDLE or DONE.
REQ-007 SHALL have port resp_valid, input, 1 bit: resp_data holds a circuit-under-test response this cycle.
REQ-008 SHALL have port resp_data, input, WIDTH bits: CUT output word from the pattern generator's circuit.
REQ-009 SHALL have port golden_sig, input, WIDTH bits: expected signature; must be stable from start until done.
REQ-010 SHALL have port busy, output, 1 bit: high in COMPACT and COMPARE.
REQ-011 SHALL have port done, output, 1 bit: high in DONE.
REQ-012 SHALL have port pass, output, 1 bit: valid while done=1; 1 means signature == golden_sig.
REQ-013 SHALL have port signature, output, WIDTH bits: current MISR contents.
REQ-014 SHALL have port count, output, 16 bits: number of responses accepted in the current run.

Function
REQ-015 SHALL implement FSM states IDLE, COMPACT, COMPARE, DONE.
REQ-016 IDLE with start=1 SHALL go to COMPACT next cycle, clearing signature and count to 0.
REQ-017 In COMPACT, each cycle with resp_valid=1 SHALL update the MISR: sig_next = ((sig << 1) XOR (sig[WIDTH-1] ? POLY : 0)) XOR resp_data, and SHALL increment count.
REQ-018 In COMPACT, cycles with resp_valid=0 SHALL hold signature and count unchanged.
REQ-019 When the accepted response raises count to NUM_PATTERNS, the FSM SHALL enter COMPARE on the next cycle; resp_valid in COMPARE/DONE/IDLE SHALL be ignored.
REQ-020 COMPARE SHALL last exactly one cycle, register pass = (signature == golden_sig), then enter DONE.
REQ-021 Latency: done SHALL rise exactly 2 cycles after the cycle in which the final response is accepted.
REQ-022 DONE SHALL hold done, pass, signature and count stable until start=1, which restarts exactly as from IDLE (REQ-016).
REQ-023 start asserted during COMPACT or COMPARE SHALL be ignored.
REQ-024 count SHALL never exceed NUM_PATTERNS; no wrap-around.
REQ-025 NUM_PATTERNS=1 SHALL work: one accepted response, then COMPARE.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, signature=0, count=0, pass=0, done=0, busy=0, regardless of state, including mid-run.
REQ-027 A run aborted by reset SHALL NOT assert done; a new start is required.

Structure
REQ-028 The FSM state enum and the default POLY constant SHALL live in a shared package bist_pkg, together with the matching pattern-generator constants.
REQ-029 The MISR register and update SHALL be a sub-module misr (params WIDTH, POLY; ports clk, rst_n, clear, enable, data, sig); the FSM, counter and comparator stay in the top.

Verification (WIDTH=8, POLY=8'h1D, NUM_PATTERNS=4)
REQ-030 Four responses of 8'h00, golden_sig=8'h00 -> signature 8'h00, pass=1, done 2 cycles after the fourth response.
REQ-031 Responses 8'h01,00,00,00 -> signature 8'h08; golden_sig=8'h08 -> pass=1; golden_sig=8'h09 -> pass=0.
REQ-032 Responses 8'h80,00,00,00 -> 8'h80, then 8'h1D, 8'h3A, 8'h74 -> signature 8'h74 (checks feedback path).
REQ-033 resp_valid gaps (valid on cycles 1,3,6,7) -> same signature as back-to-back; count reads 1,1,2,2,2,3,4.
REQ-034 rst_n=0 after 2 responses -> all outputs zero next cycle, done never rises; start re-run completes normally.
REQ-035 start pulsed during COMPACT, and resp_valid held high in DONE -> no restart, signature/count unchanged.
